decode_branch: RTL and testbench
================================

# decode_branch

Decode stage sitting directly upstream of the fetch stage. It registers the instruction word read from ROM at the current PC and decodes it. For control-transfer opcodes it evaluates the branch condition against a Z/C/N flag register. It drives fetch's `TYPE`, `B1_OUT`, `PC_VAL` and `SR_IN` inputs, flushes the wrong-path instruction after any PC redirect, and guards the 3-entry subroutine stack against overflow and underflow.

## Interface
- `IW`, 16, instruction width; opcode `[15:11]`, operand `[10:0]`.
- `AW`, 11, PC/address width.
- `STACK_DEPTH`, 3, usable subroutine-stack entries in fetch.

Ports (reset is nreset, asynchronous, active-low; clock is clk):
- `clk`  in  1  clock.
- `nreset`  in  1  asynchronous active-low reset.
- `instr`  in  IW  ROM data for the current PC; valid combinationally.
- `flag_we`  in  1  execute stage writes the flags this cycle.
- `z_in`, `c_in`, `n_in`  in  1 each  new flag values.
- `TYPE`  out  7  bit 6 = PC-related instruction; `[5:0]` = `{1'b0, opcode}`.
- `B1_OUT`  out  1  branch taken / BSR select.
- `PC_VAL`  out  AW  target address (absolute) or BSR offset.
- `SR_IN`  out  1  instruction is BSR or RET.
- `ir_valid`  out  1  the IR holds a live instruction.
- `stack_ovf`, `stack_unf`  out  1 each  sticky stack fault flags.

## Operation
- **IR load:** every rising edge, IR <= `instr` and `ir_valid` <= 1. Exception: if the current decode redirects the PC, `ir_valid` <= 0 (one bubble).
- **Invalid IR:** while `ir_valid` = 0, all of `TYPE`, `B1_OUT`, `SR_IN` and `PC_VAL` are 0.
- **Non-control opcodes (`op[4]` = 0):** `TYPE` = `{1'b0, 1'b0, op}`, `B1_OUT` = 0, `SR_IN` = 0.
- **Control opcodes** (`TYPE[6]` = 1 unless stated otherwise):
  - `10000` JMP: `B1_OUT` = 1, `PC_VAL` = `IR[10:0]`.
  - `10001` BZ / `10010` BNZ / `10011` BC / `10100` BN: `B1_OUT` = condition, `PC_VAL` = `IR[10:0]`. A not-taken branch causes no bubble.
  - `10101` BSR: `SR_IN` = 1, `B1_OUT` = 1, `PC_VAL` = `{1'b0, IR[9:0]}` (relative offset).
  - `10110` RET: `SR_IN` = 1, `B1_OUT` = 0, `PC_VAL` = 0.
  - `10111`–`11111` are reserved and decode as NOP: `TYPE` = 0.
- **Flag register:** Z/C/N, loaded from the inputs when `flag_we` = 1.
  - Condition evaluation bypasses the register: when `flag_we` = 1 it uses the `*_in` inputs, otherwise the registered flags.
- **Depth counter (0..`STACK_DEPTH`):**
  - An executed BSR increments it.
  - An executed RET decrements it.
- **Stack faults:**
  - BSR at depth `STACK_DEPTH` is suppressed: all outputs decode as NOP (`TYPE[6]` = 0), no bubble, `stack_ovf` <= 1.
  - RET at depth 0 is suppressed the same way, and `stack_unf` <= 1.
  - Both fault flags stay set until reset.
- **Redirect:** a redirect is a taken JMP/Bcc, an executed BSR or an executed RET.

## Timing
- Decode outputs are combinational from IR, the flags and depth. Fetch applies them on the next edge.
- **Latency:** instruction at PC P appears on the outputs one cycle after PC = P. Redirect penalty is exactly 1 bubble cycle.
- **Reset (asynchronous):** IR = 0, `ir_valid` = 0, flags = 0, depth = 0, `stack_ovf` = 0, `stack_unf` = 0. Therefore every output reads 0 during and immediately after reset.
- **Deassertion:** the first edge after `nreset` deasserts loads IR with `instr`.
- **Flag write and branch in the same cycle:** the branch sees the new value (bypass); the register updates at that same edge.
- **Back-to-back redirects cannot occur:** the bubble forces the next cycle to be a NOP.
- **Reset mid-redirect:** depth clears; fetch's stack contents are abandoned.

## Configuration
- `DECODE_STACK_CHECK_EN` defined: the depth counter, BSR/RET suppression and fault flags are present as specified.
- Not defined: no depth counter; BSR and RET always pass through as executed; `stack_ovf` and `stack_unf` are tied to 0.

## Structure
- **Shared package `ev22_decode_pkg`:**
  - opcode localparams: `OP_JMP`, `OP_BZ`, `OP_BNZ`, `OP_BC`, `OP_BN`, `OP_BSR`, `OP_RET`;
  - `TYPE_PC_BIT` = 6;
  - `IW` / `AW` defaults;
  - flag-index constants.
- **Sub-module `branch_cond`:** combinational. Takes the opcode and the effective Z/C/N; outputs `taken` and `is_cond`.

## Test plan
- **Reset:** hold `nreset` low mid-stream → all outputs 0 and `ir_valid` = 0; the first edge after release loads `instr`.
- **JMP:** `instr` = 16'h8123 → next cycle `TYPE[6]` = 1, `B1_OUT` = 1, `PC_VAL` = 11'h123; following cycle `ir_valid` = 0 and `TYPE` = 0.
- **Conditional branches:**
  - BZ 16'h8855 with `flag_we` = 1 and `z_in` = 1 in the decode cycle → `B1_OUT` = 1, `PC_VAL` = 11'h055.
  - Same with Z = 0 → `B1_OUT` = 0 and no bubble.
- **Stack overflow:** four nested BSRs (16'hA805) with no RET → first three give `SR_IN` = 1, `B1_OUT` = 1, `PC_VAL` = 5; the fourth gives `TYPE[6]` = 0 and `stack_ovf` = 1, which persists.
- **Stack underflow:** RET (16'hB000) at depth 0 → `TYPE[6]` = 0, `stack_unf` = 1. After one BSR, RET → `SR_IN` = 1, `B1_OUT` = 0, depth returns to 0.
- **Reserved opcode / macro off:**
  - Reserved opcode 16'hB800 → `TYPE` = 0, no bubble.
  - With `DECODE_STACK_CHECK_EN` undefined, the fourth BSR passes with `SR_IN` = 1 and the fault flags stay 0.

Source files
------------

// File: rtl/ev22_decode_pkg.sv
// Shared decode definitions: opcodes, TYPE layout, flag indices and
// default widths used by the decode stage and its branch-condition helper.
package ev22_decode_pkg;

    localparam int IW_DEFAULT          = 16;
    localparam int AW_DEFAULT          = 11;
    localparam int STACK_DEPTH_DEFAULT = 3;

    // Control-transfer opcodes (all have bit 4 set)
    localparam logic [4:0] OP_JMP = 5'b10000;
    localparam logic [4:0] OP_BZ  = 5'b10001;
    localparam logic [4:0] OP_BNZ = 5'b10010;
    localparam logic [4:0] OP_BC  = 5'b10011;
    localparam logic [4:0] OP_BN  = 5'b10100;
    localparam logic [4:0] OP_BSR = 5'b10101;
    localparam logic [4:0] OP_RET = 5'b10110;

    // Bit of TYPE that tells fetch the instruction touches the PC
    localparam int TYPE_PC_BIT = 6;

    // Positions of the flags inside the flag register
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    // Opcodes with bit 4 set belong to the control-transfer group
    function automatic logic is_ctrl_op(input logic [4:0] op);
        return op[4];
    endfunction

endpackage

// File: rtl/decode_branch_cond.sv
// Combinational branch-condition evaluator. Given an opcode and the
// effective Z/C/N flags, reports whether the opcode is a conditional
// branch and whether its condition holds.
import ev22_decode_pkg::*;

module branch_cond (
    input  logic [4:0] op_i,
    input  logic       z_i,
    input  logic       c_i,
    input  logic       n_i,
    output logic       taken_o,
    output logic       is_cond_o
);

    // Evaluate the condition of BZ/BNZ/BC/BN; everything else is not conditional
    always_comb begin
        taken_o   = 1'b0;
        is_cond_o = 1'b0;
        case (op_i)
            OP_BZ: begin
                taken_o   = z_i;
                is_cond_o = 1'b1;
            end
            OP_BNZ: begin
                taken_o   = ~z_i;
                is_cond_o = 1'b1;
            end
            OP_BC: begin
                taken_o   = c_i;
                is_cond_o = 1'b1;
            end
            OP_BN: begin
                taken_o   = n_i;
                is_cond_o = 1'b1;
            end
            default: begin
                taken_o   = 1'b0;
                is_cond_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_branch.sv
// Decode stage feeding fetch. Registers the ROM word, decodes it, resolves
// branch conditions against a bypassed Z/C/N flag register and inserts one
// bubble after every PC redirect.
// Optional feature macro: DECODE_STACK_CHECK_EN -- when defined, tracks the
// subroutine-stack depth, suppresses BSR at full depth / RET at empty depth
// and raises sticky stack_ovf / stack_unf flags.
import ev22_decode_pkg::*;

module decode_branch #(
    parameter int IW          = ev22_decode_pkg::IW_DEFAULT,
    parameter int AW          = ev22_decode_pkg::AW_DEFAULT,
    parameter int STACK_DEPTH = ev22_decode_pkg::STACK_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [IW-1:0] instr,
    input  logic          flag_we,
    input  logic          z_in,
    input  logic          c_in,
    input  logic          n_in,
    output logic [6:0]    TYPE,
    output logic          B1_OUT,
    output logic [AW-1:0] PC_VAL,
    output logic          SR_IN,
    output logic          ir_valid,
    output logic          stack_ovf,
    output logic          stack_unf
);

    logic [IW-1:0] ir_q;
    logic          ir_valid_q;
    logic [2:0]    flags_q;

    logic [4:0]    op_s;
    logic [AW-1:0] operand_s;
    logic          z_eff_s;
    logic          c_eff_s;
    logic          n_eff_s;
    logic          cond_taken_s;
    logic          is_cond_s;

    logic [6:0]    type_s;
    logic          b1_s;
    logic [AW-1:0] pc_val_s;
    logic          sr_s;
    logic          redirect_s;
    logic          bsr_exec_s;
    logic          ret_exec_s;
    logic          ovf_set_s;
    logic          unf_set_s;
    logic          bsr_block_s;
    logic          ret_block_s;

    assign op_s      = ir_q[IW-1:IW-5];
    assign operand_s = ir_q[AW-1:0];

    // A flag write in the decode cycle is visible to the branch immediately
    assign z_eff_s = flag_we ? z_in : flags_q[FLAG_Z];
    assign c_eff_s = flag_we ? c_in : flags_q[FLAG_C];
    assign n_eff_s = flag_we ? n_in : flags_q[FLAG_N];

    branch_cond u_branch_cond (
        .op_i      (op_s),
        .z_i       (z_eff_s),
        .c_i       (c_eff_s),
        .n_i       (n_eff_s),
        .taken_o   (cond_taken_s),
        .is_cond_o (is_cond_s)
    );

`ifdef DECODE_STACK_CHECK_EN
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          unf_q;
    logic          unf_d;

    assign bsr_block_s = (depth_q == DW'(STACK_DEPTH));
    assign ret_block_s = (depth_q == '0);

    // Next depth follows executed BSR/RET; fault flags only ever set
    always_comb begin
        depth_d = depth_q;
        if (bsr_exec_s) begin
            depth_d = depth_q + DW'(1);
        end else if (ret_exec_s) begin
            depth_d = depth_q - DW'(1);
        end else begin
            depth_d = depth_q;
        end
        ovf_d = ovf_q | ovf_set_s;
        unf_d = unf_q | unf_set_s;
    end

    // Depth counter and sticky stack fault flags
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    logic stack_unused_s;

    assign bsr_block_s    = 1'b0;
    assign ret_block_s    = 1'b0;
    assign stack_ovf      = 1'b0;
    assign stack_unf      = 1'b0;
    assign stack_unused_s = ^{bsr_exec_s, ret_exec_s, ovf_set_s, unf_set_s, 1'(STACK_DEPTH)};
`endif

    // Decode the IR into fetch controls and flag redirects / stack events
    always_comb begin
        type_s     = 7'd0;
        b1_s       = 1'b0;
        pc_val_s   = '0;
        sr_s       = 1'b0;
        redirect_s = 1'b0;
        bsr_exec_s = 1'b0;
        ret_exec_s = 1'b0;
        ovf_set_s  = 1'b0;
        unf_set_s  = 1'b0;
        if (!ir_valid_q) begin
            type_s = 7'd0;
        end else if (!is_ctrl_op(op_s)) begin
            type_s = {2'b00, op_s};
        end else begin
            case (op_s)
                OP_JMP, OP_BZ, OP_BNZ, OP_BC, OP_BN: begin
                    type_s                = {2'b00, op_s};
                    type_s[TYPE_PC_BIT]   = 1'b1;
                    b1_s                  = is_cond_s ? cond_taken_s : 1'b1;
                    pc_val_s              = operand_s;
                    redirect_s            = b1_s;
                end
                OP_BSR: begin
                    if (bsr_block_s) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        type_s              = {2'b00, op_s};
                        type_s[TYPE_PC_BIT] = 1'b1;
                        sr_s                = 1'b1;
                        b1_s                = 1'b1;
                        pc_val_s            = {1'b0, operand_s[AW-2:0]};
                        redirect_s          = 1'b1;
                        bsr_exec_s          = 1'b1;
                    end
                end
                OP_RET: begin
                    if (ret_block_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        type_s              = {2'b00, op_s};
                        type_s[TYPE_PC_BIT] = 1'b1;
                        sr_s                = 1'b1;
                        redirect_s          = 1'b1;
                        ret_exec_s          = 1'b1;
                    end
                end
                default: begin
                    type_s = 7'd0;
                end
            endcase
        end
    end

    // IR, valid bit (dropped for one cycle after a redirect) and flag register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            flags_q    <= 3'b000;
        end else begin
            ir_q       <= instr;
            ir_valid_q <= ~redirect_s;
            if (flag_we) begin
                flags_q[FLAG_Z] <= z_in;
                flags_q[FLAG_C] <= c_in;
                flags_q[FLAG_N] <= n_in;
            end else begin
                flags_q <= flags_q;
            end
        end
    end

    assign TYPE     = type_s;
    assign B1_OUT   = b1_s;
    assign PC_VAL   = pc_val_s;
    assign SR_IN    = sr_s;
    assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_decode_branch.sv
// Directed bench for decode_branch: reset, JMP, conditional branches with
// bypassed and registered flags, reserved opcode, stack under/overflow and
// reset mid-stream. Expectations follow DECODE_STACK_CHECK_EN.
module tb_decode_branch;

    logic        clk;
    logic        nreset;
    logic [15:0] instr;
    logic        flag_we;
    logic        z_in;
    logic        c_in;
    logic        n_in;
    logic [6:0]  TYPE;
    logic        B1_OUT;
    logic [10:0] PC_VAL;
    logic        SR_IN;
    logic        ir_valid;
    logic        stack_ovf;
    logic        stack_unf;

    int total;
    int bad;

`ifdef DECODE_STACK_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    decode_branch dut (
        .clk       (clk),
        .nreset    (nreset),
        .instr     (instr),
        .flag_we   (flag_we),
        .z_in      (z_in),
        .c_in      (c_in),
        .n_in      (n_in),
        .TYPE      (TYPE),
        .B1_OUT    (B1_OUT),
        .PC_VAL    (PC_VAL),
        .SR_IN     (SR_IN),
        .ir_valid  (ir_valid),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [15:0] v);
        instr = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        nreset  = 1'b0;
        instr   = 16'h0805;
        flag_we = 1'b0;
        z_in    = 1'b0;
        c_in    = 1'b0;
        n_in    = 1'b0;

        // Reset state
        #12;
        chk("rst_type", 32'(TYPE), 32'h0);
        chk("rst_b1", 32'(B1_OUT), 32'h0);
        chk("rst_pc", 32'(PC_VAL), 32'h0);
        chk("rst_sr", 32'(SR_IN), 32'h0);
        chk("rst_vld", 32'(ir_valid), 32'h0);
        chk("rst_ovf", 32'(stack_ovf), 32'h0);
        chk("rst_unf", 32'(stack_unf), 32'h0);
        @(negedge clk);
        nreset = 1'b1;

        // First edge loads a non-control instruction (opcode 00001)
        tick(16'h0805);
        chk("load_vld", 32'(ir_valid), 32'h1);
        chk("load_type", 32'(TYPE), 32'h01);
        chk("load_b1", 32'(B1_OUT), 32'h0);

        // JMP then bubble
        tick(16'h8123);
        chk("jmp_type", 32'(TYPE), 32'h50);
        chk("jmp_b1", 32'(B1_OUT), 32'h1);
        chk("jmp_pc", 32'(PC_VAL), 32'h123);
        tick(16'h0000);
        chk("jmp_bub_vld", 32'(ir_valid), 32'h0);
        chk("jmp_bub_type", 32'(TYPE), 32'h0);

        // BZ taken via bypassed z_in, register picks up Z=1 at the same edge
        tick(16'h8855);
        flag_we = 1'b1;
        z_in    = 1'b1;
        #1;
        chk("bz_t_b1", 32'(B1_OUT), 32'h1);
        chk("bz_t_pc", 32'(PC_VAL), 32'h055);
        chk("bz_t_type", 32'(TYPE), 32'h51);
        tick(16'h0000);
        flag_we = 1'b0;
        z_in    = 1'b0;
        chk("bz_t_bub_vld", 32'(ir_valid), 32'h0);

        // BNZ against registered Z=1: not taken
        tick(16'h9055);
        chk("bnz_b1", 32'(B1_OUT), 32'h0);
        chk("bnz_type", 32'(TYPE), 32'h52);

        // BZ with bypassed Z=0 overriding registered Z=1: not taken, no bubble
        tick(16'h8855);
        flag_we = 1'b1;
        z_in    = 1'b0;
        #1;
        chk("bz_nt_b1", 32'(B1_OUT), 32'h0);
        chk("bz_nt_pc", 32'(PC_VAL), 32'h055);
        tick(16'h0000);
        flag_we = 1'b0;
        chk("bz_nt_vld", 32'(ir_valid), 32'h1);

        // BC via bypassed C=1, then bubble (C register becomes 1)
        tick(16'h9810);
        flag_we = 1'b1;
        c_in    = 1'b1;
        #1;
        chk("bc_b1", 32'(B1_OUT), 32'h1);
        chk("bc_pc", 32'(PC_VAL), 32'h010);
        tick(16'h0000);
        flag_we = 1'b0;
        c_in    = 1'b0;

        // BN with N=0 not taken; BC with registered C=1 taken
        tick(16'hA033);
        chk("bn_b1", 32'(B1_OUT), 32'h0);
        chk("bn_type", 32'(TYPE), 32'h54);
        tick(16'h9822);
        chk("bc_reg_b1", 32'(B1_OUT), 32'h1);
        chk("bc_reg_pc", 32'(PC_VAL), 32'h022);
        tick(16'h0000);

        // Reserved opcode 10111 decodes as NOP without a bubble
        tick(16'hB87F);
        chk("rsv_type", 32'(TYPE), 32'h0);
        chk("rsv_b1", 32'(B1_OUT), 32'h0);
        chk("rsv_pc", 32'(PC_VAL), 32'h0);

        // RET at depth 0
        tick(16'hB000);
        chk("rsv_next_vld", 32'(ir_valid), 32'h1);
        chk("ret0_type", 32'(TYPE), CHK_EN ? 32'h0 : 32'h56);
        chk("ret0_sr", 32'(SR_IN), CHK_EN ? 32'h0 : 32'h1);
        chk("ret0_b1", 32'(B1_OUT), 32'h0);
        tick(16'h0000);
        chk("ret0_unf", 32'(stack_unf), CHK_EN ? 32'h1 : 32'h0);
        chk("ret0_vld", 32'(ir_valid), CHK_EN ? 32'h1 : 32'h0);

        // One BSR then RET returns depth to 0
        tick(16'hA805);
        chk("bsr1_type", 32'(TYPE), 32'h55);
        chk("bsr1_sr", 32'(SR_IN), 32'h1);
        chk("bsr1_b1", 32'(B1_OUT), 32'h1);
        chk("bsr1_pc", 32'(PC_VAL), 32'h005);
        tick(16'hB000);
        chk("bsr1_bub_vld", 32'(ir_valid), 32'h0);
        tick(16'hB000);
        chk("ret1_type", 32'(TYPE), 32'h56);
        chk("ret1_sr", 32'(SR_IN), 32'h1);
        chk("ret1_b1", 32'(B1_OUT), 32'h0);
        chk("ret1_pc", 32'(PC_VAL), 32'h0);
        tick(16'hB000);
        tick(16'hB000);
        chk("ret2_type", 32'(TYPE), CHK_EN ? 32'h0 : 32'h56);
        tick(16'h0000);
        chk("ret2_vld", 32'(ir_valid), CHK_EN ? 32'h1 : 32'h0);

        // Four nested BSRs
        for (int i = 0; i < 4; i++) begin
            tick(16'hA805);
            if (CHK_EN && i == 3) begin
                chk("bsr_ovf_type", 32'(TYPE), 32'h0);
                chk("bsr_ovf_sr", 32'(SR_IN), 32'h0);
            end else begin
                chk("bsr_n_sr", 32'(SR_IN), 32'h1);
                chk("bsr_n_pc", 32'(PC_VAL), 32'h005);
            end
            tick(16'h0000);
            chk("bsr_n_vld", 32'(ir_valid), (CHK_EN && i == 3) ? 32'h1 : 32'h0);
            chk("bsr_n_ovf", 32'(stack_ovf), (CHK_EN && i == 3) ? 32'h1 : 32'h0);
        end
        tick(16'h0000);
        tick(16'h0805);
        chk("ovf_persist", 32'(stack_ovf), CHK_EN ? 32'h1 : 32'h0);
        chk("unf_persist", 32'(stack_unf), CHK_EN ? 32'h1 : 32'h0);

        // Reset mid-stream clears everything including depth
        tick(16'hA805);
        #2;
        nreset = 1'b0;
        #1;
        chk("rst2_type", 32'(TYPE), 32'h0);
        chk("rst2_sr", 32'(SR_IN), 32'h0);
        chk("rst2_vld", 32'(ir_valid), 32'h0);
        chk("rst2_ovf", 32'(stack_ovf), 32'h0);
        chk("rst2_unf", 32'(stack_unf), 32'h0);
        @(negedge clk);
        nreset = 1'b1;
        tick(16'hA805);
        chk("post_rst_vld", 32'(ir_valid), 32'h1);
        chk("post_rst_sr", 32'(SR_IN), 32'h1);
        chk("post_rst_b1", 32'(B1_OUT), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
